// File: rtl/board_writer.sv
// board_writer: owns white/black stone bitmaps and counts, applies one move at a time (place, then FLIPS_PER_CYCLE-bit flip chunks); BOARD_WRITER_OCCUPY_CHECK_EN rejects occupied targets via err
module board_writer #(
  parameter int FLIPS_PER_CYCLE = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_pos,
  input  logic        req_color,
  input  logic [63:0] req_flip,
  output logic        done,
  output logic        err,
  output logic [63:0] WhiteData,
  output logic [63:0] BlackData,
  output logic [7:0]  cnt_white,
  output logic [7:0]  cnt_black
);
  localparam int N = 64 / FLIPS_PER_CYCLE;
  localparam logic [63:0] CHUNK0 = (64'd1 << FLIPS_PER_CYCLE) - 64'd1;
  localparam logic [63:0] W_INIT = (64'd1 << 27) | (64'd1 << 36);
  localparam logic [63:0] B_INIT = (64'd1 << 28) | (64'd1 << 35);
  typedef enum logic [2:0] {IDLE, PLACE, FLIP, DONE, ERR} state_t;
  state_t      state_q, state_d;
  logic [5:0]  pos_q, pos_d;
  logic        col_q, col_d;
  logic [63:0] flip_q, flip_d, w_q, w_d, b_q, b_d;
  logic [7:0]  cw_q, cw_d, cb_q, cb_d;
  logic [6:0]  k_q, k_d;
  logic [63:0] mov, opp, mov_n, opp_n, posbit, flips;
  logic [7:0]  mcnt, ocnt, mcnt_n, ocnt_n, pc;

  function automatic logic [7:0] popcnt(input logic [63:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c = c + {7'd0, v[i]};
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    pos_d = pos_q;
    col_d = col_q;
    flip_d = flip_q;
    k_d = k_q;
    mov = col_q ? w_q : b_q;
    opp = col_q ? b_q : w_q;
    mcnt = col_q ? cw_q : cb_q;
    ocnt = col_q ? cb_q : cw_q;
    mov_n = mov;
    opp_n = opp;
    mcnt_n = mcnt;
    ocnt_n = ocnt;
    posbit = 64'd1 << pos_q;
    flips = flip_q & opp & ~posbit & (CHUNK0 << (32'(k_q) * FLIPS_PER_CYCLE));
    pc = popcnt(flips);
    case (state_q)
      IDLE: if (req_valid) begin
        pos_d = req_pos;
        col_d = req_color;
        flip_d = req_flip;
        state_d = PLACE;
      end
      PLACE: begin
        k_d = '0;
        state_d = FLIP;
`ifdef BOARD_WRITER_OCCUPY_CHECK_EN
        if (|((w_q | b_q) & posbit)) state_d = ERR;
        else begin
          mov_n = mov | posbit;
          mcnt_n = mcnt + 8'd1;
        end
`else
        if (!mov[pos_q]) begin
          mov_n = mov | posbit;
          mcnt_n = mcnt + 8'd1;
          opp_n = opp & ~posbit;
          ocnt_n = opp[pos_q] ? ocnt - 8'd1 : ocnt;
        end
`endif
      end
      FLIP: begin
        mov_n = mov | flips;
        opp_n = opp & ~flips;
        mcnt_n = mcnt + pc;
        ocnt_n = ocnt - pc;
        k_d = k_q + 7'd1;
        state_d = (k_q == 7'(N - 1)) ? DONE : FLIP;
      end
      default: state_d = IDLE;
    endcase
    w_d = col_q ? mov_n : opp_n;
    b_d = col_q ? opp_n : mov_n;
    cw_d = col_q ? mcnt_n : ocnt_n;
    cb_d = col_q ? ocnt_n : mcnt_n;
  end

  always_ff @(posedge clk) begin
    if (rst || init) begin
      state_q <= IDLE;
      pos_q <= '0;
      col_q <= 1'b0;
      flip_q <= '0;
      k_q <= '0;
      w_q <= W_INIT;
      b_q <= B_INIT;
      cw_q <= 8'd2;
      cb_q <= 8'd2;
    end else begin
      state_q <= state_d;
      pos_q <= pos_d;
      col_q <= col_d;
      flip_q <= flip_d;
      k_q <= k_d;
      w_q <= w_d;
      b_q <= b_d;
      cw_q <= cw_d;
      cb_q <= cb_d;
    end
  end

  assign req_ready = state_q == IDLE;
  assign done = state_q == DONE;
`ifdef BOARD_WRITER_OCCUPY_CHECK_EN
  assign err = state_q == ERR;
`else
  assign err = 1'b0;
`endif
  assign WhiteData = w_q;
  assign BlackData = b_q;
  assign cnt_white = cw_q;
  assign cnt_black = cb_q;
endmodule

// File: tb/tb_board_writer.sv
// tb_board_writer: directed checks of board_writer at F=8 and F=1
module tb_board_writer;
  logic clk = 1'b0, rst = 1'b1, init = 1'b0, req_valid = 1'b0, req_color = 1'b0;
  logic [5:0] req_pos = '0;
  logic [63:0] req_flip = '0;
  logic r8, d8, e8, r1, d1, e1;
  logic [63:0] w8, b8, w1, b1;
  logic [7:0] cw8, cb8, cw1, cb1;
  int checks = 0, passed = 0, inv_bad = 0;
  localparam logic [63:0] W0 = (64'd1 << 27) | (64'd1 << 36);
  localparam logic [63:0] B0 = (64'd1 << 28) | (64'd1 << 35);

  always #5 clk = ~clk;

  board_writer #(.FLIPS_PER_CYCLE(8)) dut8 (.clk(clk), .rst(rst), .init(init), .req_valid(req_valid),
    .req_ready(r8), .req_pos(req_pos), .req_color(req_color), .req_flip(req_flip), .done(d8), .err(e8),
    .WhiteData(w8), .BlackData(b8), .cnt_white(cw8), .cnt_black(cb8));
  board_writer #(.FLIPS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .init(init), .req_valid(req_valid),
    .req_ready(r1), .req_pos(req_pos), .req_color(req_color), .req_flip(req_flip), .done(d1), .err(e1),
    .WhiteData(w1), .BlackData(b1), .cnt_white(cw1), .cnt_black(cb1));

  always @(negedge clk) if (!rst) begin
    if ((w8 & b8) != 0 || cw8 != 8'($countones(w8)) || cb8 != 8'($countones(b8))) inv_bad++;
    if ((w1 & b1) != 0 || cw1 != 8'($countones(w1)) || cb1 != 8'($countones(b1))) inv_bad++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_init();
    req_valid = 1'b0;
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  task automatic run_move(input logic [5:0] pos, input logic col, input logic [63:0] fl,
                          output int done_cyc, output int err_cyc);
    done_cyc = -1;
    err_cyc = -1;
    req_pos = pos;
    req_color = col;
    req_flip = fl;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_pos = 6'd63;
    req_flip = '1;
    req_color = ~col;
    for (int c = 1; c < 80; c++) begin
      if (d8) begin done_cyc = c; break; end
      if (e8) begin err_cyc = c; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    checks++; if ({w8, b8} !== {W0, B0}) $display("FAIL reset_boards got %h/%h want %h/%h", w8, b8, W0, B0); else passed++;
    checks++; if ({cw8, cb8} !== {8'd2, 8'd2}) $display("FAIL reset_counts got %0d/%0d want 2/2", cw8, cb8); else passed++;
    checks++; if ({r8, d8, e8} !== 3'b100) $display("FAIL reset_ctrl got ready/done/err %b%b%b want 100", r8, d8, e8); else passed++;
    checks++; if ({w1, b1, cw1, cb1, r1, d1, e1} !== {W0, B0, 8'd2, 8'd2, 3'b100}) $display("FAIL reset_f1 got %h/%h", w1, b1); else passed++;
  endtask

  task automatic test_single_flip();
    int dc, ec;
    logic [63:0] eb, ew;
    eb = (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 28) | (64'd1 << 35);
    ew = 64'd1 << 36;
    pulse_init();
    run_move(6'd19, 1'b0, 64'd1 << 27, dc, ec);
    checks++; if (dc !== 10) $display("FAIL single_done_cycle got %0d want 10", dc); else passed++;
    checks++; if ({w8, b8} !== {ew, eb}) $display("FAIL single_boards got %h/%h want %h/%h", w8, b8, ew, eb); else passed++;
    checks++; if ({cw8, cb8} !== {8'd1, 8'd4}) $display("FAIL single_counts got %0d/%0d want 1/4", cw8, cb8); else passed++;
    checks++; if (r8 !== 1'b0) $display("FAIL single_ready_in_done got %b want 0", r8); else passed++;
    tick();
    checks++; if ({r8, d8} !== 2'b10) $display("FAIL single_after got ready/done %b%b want 10", r8, d8); else passed++;
  endtask

  task automatic test_ignored_mask();
    int dc, ec;
    logic [63:0] eb;
    eb = (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 28) | (64'd1 << 35);
    pulse_init();
    run_move(6'd19, 1'b0, (64'd1 << 27) | (64'd1 << 28) | 64'd1, dc, ec);
    checks++; if (dc !== 10) $display("FAIL ignored_done_cycle got %0d want 10", dc); else passed++;
    checks++; if ({w8, b8, cw8, cb8} !== {64'd1 << 36, eb, 8'd1, 8'd4}) $display("FAIL ignored_result got %h/%h %0d/%0d", w8, b8, cw8, cb8); else passed++;
  endtask

  task automatic test_multi_flip();
    int dc, ec;
    logic [63:0] ew;
    ew = W0 | B0 | (64'd1 << 37);
    pulse_init();
    run_move(6'd37, 1'b1, '1, dc, ec);
    checks++; if (dc !== 10) $display("FAIL multi_done_cycle got %0d want 10", dc); else passed++;
    checks++; if ({w8, b8} !== {ew, 64'd0}) $display("FAIL multi_boards got %h/%h want %h/0", w8, b8, ew); else passed++;
    checks++; if ({cw8, cb8} !== {8'd5, 8'd0}) $display("FAIL multi_counts got %0d/%0d want 5/0", cw8, cb8); else passed++;
  endtask

  task automatic test_occupied();
    int dc, ec;
    pulse_init();
    run_move(6'd27, 1'b1, '0, dc, ec);
`ifdef BOARD_WRITER_OCCUPY_CHECK_EN
    checks++; if ({ec, dc} !== {32'd2, -32'sd1}) $display("FAIL occ_err_cycle got err %0d done %0d want 2/-1", ec, dc); else passed++;
    checks++; if ({w8, b8, cw8, cb8} !== {W0, B0, 8'd2, 8'd2}) $display("FAIL occ_unchanged got %h/%h %0d/%0d", w8, b8, cw8, cb8); else passed++;
    tick();
    checks++; if ({r8, e8} !== 2'b10) $display("FAIL occ_after got ready/err %b%b want 10", r8, e8); else passed++;
`else
    checks++; if ({dc, ec} !== {32'd10, -32'sd1}) $display("FAIL occ_done_cycle got done %0d err %0d want 10/-1", dc, ec); else passed++;
    checks++; if ({w8, b8, cw8, cb8} !== {W0, B0, 8'd2, 8'd2}) $display("FAIL occ_unchanged got %h/%h %0d/%0d", w8, b8, cw8, cb8); else passed++;
    pulse_init();
    run_move(6'd28, 1'b1, '0, dc, ec);
    checks++; if ({w8, b8, cw8, cb8} !== {W0 | (64'd1 << 28), 64'd1 << 35, 8'd3, 8'd1}) $display("FAIL occ_steal got %h/%h %0d/%0d", w8, b8, cw8, cb8); else passed++;
`endif
  endtask

  task automatic test_init_abort();
    bit saw;
    pulse_init();
    req_pos = 6'd19;
    req_color = 1'b0;
    req_flip = 64'd1 << 27;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    init = 1'b1;
    tick();
    init = 1'b0;
    checks++; if ({w8, b8, cw8, cb8} !== {W0, B0, 8'd2, 8'd2}) $display("FAIL abort_position got %h/%h %0d/%0d", w8, b8, cw8, cb8); else passed++;
    checks++; if ({r8, d8, e8} !== 3'b100) $display("FAIL abort_ctrl got %b%b%b want 100", r8, d8, e8); else passed++;
    saw = 1'b0;
    repeat (12) begin
      if (d8 || e8) saw = 1'b1;
      tick();
    end
    checks++; if (saw !== 1'b0) $display("FAIL abort_pulse got pulse %b want 0", saw); else passed++;
  endtask

  task automatic test_back_to_back();
    int dc;
    pulse_init();
    req_pos = 6'd19;
    req_color = 1'b0;
    req_flip = 64'd1 << 27;
    req_valid = 1'b1;
    tick();
    dc = -1;
    for (int c = 1; c < 200; c++) begin
      if (d1) begin dc = c; break; end
      tick();
    end
    checks++; if (dc !== 66) $display("FAIL b2b_done_cycle got %0d want 66", dc); else passed++;
    checks++; if ({w1, b1, cw1, cb1} !== {64'd1 << 36, (64'd1 << 19) | (64'd1 << 27) | B0, 8'd1, 8'd4}) $display("FAIL b2b_result got %h/%h %0d/%0d", w1, b1, cw1, cb1); else passed++;
    tick();
    checks++; if (r1 !== 1'b1) $display("FAIL b2b_ready67 got %b want 1", r1); else passed++;
    tick();
    checks++; if (r1 !== 1'b0) $display("FAIL b2b_accept68 got ready %b want 0", r1); else passed++;
    req_valid = 1'b0;
    pulse_init();
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    test_reset();
    test_single_flip();
    test_ignored_mask();
    test_multi_flip();
    test_occupied();
    test_init_abort();
    test_back_to_back();
    repeat (2) tick();
    checks++; if (inv_bad !== 0) $display("FAIL invariants got %0d bad cycles want 0", inv_bad); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/board_writer.md
# board_writer

Owner of the two 64-bit stone bitmaps (`WhiteData`, `BlackData`) that the score counter and display logic consume. Accepts one move request at a time: cell index, mover colour and flip mask. It places the stone, then flips opponent stones over several cycles. It keeps running stone counts incrementally, so `cnt_white`/`cnt_black` always equal the popcount of the boards. It is the write side of the board interface; all other blocks only read the bitmaps.

## Interface
- `FLIPS_PER_CYCLE`, 8, mask bits processed per FLIP cycle; legal values 1,2,4,8,16,32,64; N = 64/FLIPS_PER_CYCLE FLIP cycles.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `init`  in  1  synchronous new-game load; any state.
- `req_valid`  in  1  move request valid.
- `req_ready`  out  1  block idle, request accepted when `req_valid & req_ready`.
- `req_pos`  in  6  target cell, index = row*8+col.
- `req_color`  in  1  mover: 1 = white, 0 = black.
- `req_flip`  in  64  cells to flip to mover colour.
- `done`  out  1  one-cycle pulse, move committed.
- `err`  out  1  one-cycle pulse, move rejected.
- `WhiteData`, `BlackData`  out  64 each  board bitmaps, registered.
- `cnt_white`, `cnt_black`  out  8 each  registered stone counts.

## Operation
- Initial position: `WhiteData` bits 27,36 set; `BlackData` bits 28,35 set; counts 2/2.
- States: IDLE, PLACE, FLIP, DONE, ERR.
- IDLE: `req_ready`=1. On handshake, latch pos/colour/mask, go to PLACE.
- PLACE: if cell occupied in either board, go to ERR with boards unchanged. Else set the mover bit, increment the mover count, clear chunk counter k, go to FLIP.
- FLIP: chunk k = bits [k*F +: F]. Flip bits = mask & opponent board & chunk. Move them from the opponent to the mover. Mover count += popcount, opponent count −= popcount, in the same cycle. Mask bits on empty or own cells, and the bit at `req_pos`, are ignored. After k = N−1, go to DONE.
- DONE: `done`=1, `req_ready`=0, then IDLE.
- ERR: `err`=1, `req_ready`=0, then IDLE.
- Counts are 8-bit. The sum of the counts is ≤64 by invariant, so no overflow or underflow is possible.
- Invariants, all cycles: `WhiteData & BlackData` == 0; each count equals the popcount of its board.
- `init` (when `rst`=0): reload the initial position, counts 2/2, state IDLE, clear `done`/`err`. Aborts any in-flight move with no pulse.
- `rst`: same effect as `init` and takes priority over it.

## Timing
- Reset values: `req_ready`=1, `done`=0, `err`=0, boards at the initial position, `cnt_white`=`cnt_black`=2.
- Handshake in cycle 0. PLACE is cycle 1. FLIP runs cycles 2..N+1. `done` is high in cycle N+2, with final boards and counts visible that cycle. `req_ready`=1 from cycle N+3.
- Reject: `err` high in cycle 2, `req_ready`=1 from cycle 3.
- `req_valid` may stay high while busy. No acceptance while `req_ready`=0. The request is accepted on the first ready cycle.
- The latched request is immune to input changes after the handshake.

## Configuration
- `BOARD_WRITER_OCCUPY_CHECK_EN` defined: occupied target goes to ERR as above.
- Not defined: ERR is unreachable and `err` is tied 0. Placement proceeds and then FLIP/DONE run as normal:
  - cell owned by the opponent: bit moves to the mover, mover count +1, opponent count −1;
  - cell owned by the mover: no change.

## Test plan
- Reset, F=8: boards 27,36 / 28,35, counts 2/2, `req_ready`=1, `done`=`err`=0.
- Black, pos 19, mask {27}: `done` in cycle 10; `BlackData` {19,27,28,35}, `WhiteData` {36}, counts white 1 / black 4.
- Same move, mask {27,28,0}: identical result. Own cell 28 and empty cell 0 are ignored.
- With `BOARD_WRITER_OCCUPY_CHECK_EN`: white, pos 27 → `err` in cycle 2, boards and counts unchanged, `req_ready`=1 in cycle 3. Without the macro: `WhiteData` unchanged, `done` in cycle 10.
- `init` in cycle 5 of a move → cycle 6 shows the initial position, counts 2/2, IDLE; no `done` pulse.
- F=1, `req_valid` held through the busy period: `done` in cycle 66, second request accepted in cycle 67. Counts match board popcounts every cycle.
